wb_cas_arbiter: RTL and testbench

- Shares one wb_cas_fsm compare-and-swap unit between N Wishbone requesters (cores).
- A CAS is a 4-transaction sequence on the unit's slave port: write address, write compare value, write swap value, then a read that returns the old value. Interleaving sequences from two cores corrupts the unit's state.
- The arbiter therefore grants round-robin, locks the grant for a full sequence, and rejects out-of-order accesses.
- A watchdog resets the CAS unit if an owner abandons a sequence part-way.

---
 rtl/wb_cas_pkg.sv | 17 +
 rtl/wb_cas_rr_pick.sv | 33 +++
 rtl/wb_cas_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_cas_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cas_pkg.sv
// Shared constants for the Wishbone CAS arbiter.
// Arbiter FSM encodings and CAS sequence phases.
package wb_cas_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ABORT  = 2'd2;

    localparam logic [1:0] PH_ADR = 2'd0;
    localparam logic [1:0] PH_CMP = 2'd1;
    localparam logic [1:0] PH_VAL = 2'd2;
    localparam logic [1:0] PH_RD  = 2'd3;

    localparam int N_DEF       = 4;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/wb_cas_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above the pointer, wrapping past N-1 back to 0.
module wb_cas_rr_pick
    import wb_cas_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW:0] w_c;

    // Descending scan so the candidate closest to the pointer wins.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        w_c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_c = {1'b0, i_ptr} + (IW + 1)'(i);
            if (w_c >= (IW + 1)'(N)) begin
                w_c = w_c - (IW + 1)'(N);
            end
            if (i_req[w_c[IW-1:0]]) begin
                o_idx = w_c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_cas_arbiter.sv
// Round-robin arbiter sharing one CAS unit between N requesters,
// locking the grant for a full 4-access sequence with a watchdog.
module wb_cas_arbiter
    import wb_cas_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N*32-1:0] m_adr_i,
    input  logic [N*32-1:0] m_dat_i,
    input  logic [N*4-1:0]  m_sel_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    output logic [31:0]     m_dat_o,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_err_o,
    output logic [N-1:0]    m_rty_o,
    output logic [31:0]     s_adr_o,
    output logic [31:0]     s_dat_o,
    output logic [3:0]      s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [31:0]     s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic            cas_rst_o
);

    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_ptr;
    logic [1:0]    r_phase;
    logic [CW-1:0] r_wdog;

    logic [N-1:0]  w_req;
    logic [N-1:0]  w_onehot;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_next;
    logic          w_pick_vld;
    logic          w_locked;
    logic          w_own_we;
    logic          w_own_stb;
    logic          w_own_cyc;
    logic          w_dir_ok;
    logic          w_bad_dir;

    assign w_req     = m_cyc_i & m_stb_i;
    assign w_locked  = (r_state == ST_LOCKED);
    assign w_onehot  = N'(1) << r_owner;
    assign w_own_we  = m_we_i[r_owner];
    assign w_own_stb = m_stb_i[r_owner];
    assign w_own_cyc = m_cyc_i[r_owner];
    assign w_next    = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

    // Three writes then one read; anything else is refused.
    assign w_dir_ok  = (r_phase == PH_RD) ? ~w_own_we : w_own_we;
    assign w_bad_dir = w_own_cyc & w_own_stb & ~w_dir_ok;

    wb_cas_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick),
        .o_valid (w_pick_vld)
    );

    assign s_adr_o = w_locked ? m_adr_i[32'(r_owner) * 32 +: 32] : '0;
    assign s_dat_o = w_locked ? m_dat_i[32'(r_owner) * 32 +: 32] : '0;
    assign s_sel_o = w_locked ? m_sel_i[32'(r_owner) * 4 +: 4] : '0;
    assign s_we_o  = w_locked & w_own_we;
    assign s_cyc_o = w_locked & w_own_cyc;
    assign s_stb_o = w_locked & w_own_stb & w_dir_ok;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = {N{w_locked & s_ack_i}} & w_onehot;
    assign m_rty_o   = {N{w_locked & s_rty_i}} & w_onehot;
    assign m_err_o   = {N{w_locked & (s_err_i | w_bad_dir)}} & w_onehot;
    assign cas_rst_o = (r_state == ST_ABORT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_phase <= PH_ADR;
            r_wdog  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_owner <= w_pick;
                        r_phase <= PH_ADR;
                        r_wdog  <= '0;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (s_ack_i) begin
                        r_phase <= r_phase + 2'd1;
                        if (r_phase == PH_RD) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next;
                        end
                    end
                    // A refused access neither feeds nor starves the watchdog.
                    if (w_own_stb) begin
                        if (w_dir_ok) begin
                            r_wdog <= '0;
                        end
                    end else if (r_wdog == WD_MAX) begin
                        r_ptr   <= w_next;
                        r_state <= (r_phase == PH_ADR) ? ST_IDLE : ST_ABORT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cas_arbiter.sv
// Bench for wb_cas_arbiter: directed CAS sequences against a small
// CAS unit model, with a scoreboard checking every requester response.
module tb_wb_cas_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    typedef struct {
        int          k;
        bit          err;
        bit          rd;
        logic [31:0] dat;
    } exp_t;

    logic            clk;
    logic            rst_i;
    logic [N*32-1:0] m_adr_i;
    logic [N*32-1:0] m_dat_i;
    logic [N*4-1:0]  m_sel_i;
    logic [N-1:0]    m_we_i;
    logic [N-1:0]    m_cyc_i;
    logic [N-1:0]    m_stb_i;
    logic [31:0]     m_dat_o;
    logic [N-1:0]    m_ack_o;
    logic [N-1:0]    m_err_o;
    logic [N-1:0]    m_rty_o;
    logic [31:0]     s_adr_o;
    logic [31:0]     s_dat_o;
    logic [3:0]      s_sel_o;
    logic            s_we_o;
    logic            s_cyc_o;
    logic            s_stb_o;
    logic [31:0]     s_dat_i;
    logic            s_ack_i;
    logic            s_err_i;
    logic            s_rty_i;
    logic            cas_rst_o;

    logic [31:0] t_adr [N];
    logic [31:0] t_dat [N];
    logic        t_we  [N];
    logic        t_cyc [N];
    logic        t_stb [N];
    logic [N-1:0] done;

    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    int rd_wait = 2;

    logic [31:0] mem [16];
    logic [31:0] sl_adr, sl_cmp, sl_val, sl_dat;
    logic [1:0]  sl_sp;
    logic        sl_ack;
    int          sl_cnt;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign m_adr_i[32*g +: 32] = t_adr[g];
        assign m_dat_i[32*g +: 32] = t_dat[g];
        assign m_sel_i[4*g +: 4]   = 4'hF;
        assign m_we_i[g]           = t_we[g];
        assign m_cyc_i[g]          = t_cyc[g];
        assign m_stb_i[g]          = t_stb[g];
    end

    wb_cas_arbiter #(
        .N       (N),
        .TIMEOUT (T)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_we_i    (m_we_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .cas_rst_o (cas_rst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_dat_i = sl_dat;
    assign s_ack_i = sl_ack;
    assign s_err_i = 1'b0;
    assign s_rty_i = 1'b0;

    // CAS unit model: adr, cmp, val writes then a read returning old value.
    always @(posedge clk) begin
        if (rst_i || cas_rst_o) begin
            sl_ack <= 1'b0;
            sl_cnt <= 0;
            sl_sp  <= 2'd0;
        end else if (sl_ack) begin
            sl_ack <= 1'b0;
        end else if (s_cyc_o && s_stb_o) begin
            if (!s_we_o && sl_cnt < rd_wait) begin
                sl_cnt <= sl_cnt + 1;
            end else begin
                sl_ack <= 1'b1;
                sl_cnt <= 0;
                sl_sp  <= sl_sp + 2'd1;
                if (s_we_o) begin
                    if (sl_sp == 2'd0) sl_adr <= s_dat_o;
                    else if (sl_sp == 2'd1) sl_cmp <= s_dat_o;
                    else sl_val <= s_dat_o;
                end else begin
                    sl_dat <= mem[sl_adr[5:2]];
                    if (mem[sl_adr[5:2]] == sl_cmp) mem[sl_adr[5:2]] <= sl_val;
                    sl_sp <= 2'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cas_rst_o) rst_pulses++;
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            for (int k = 0; k < N; k++) begin
                if (m_ack_o[k] || m_err_o[k]) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected k=%0d ack=%b err=%b", k, m_ack_o[k], m_err_o[k]);
                    end else begin
                        mon_e = sbq.pop_front();
                        if (mon_e.k != k || m_err_o[k] != mon_e.err || m_ack_o[k] == mon_e.err ||
                            (mon_e.rd && m_dat_o != mon_e.dat)) begin
                            errors++;
                            $display("FAIL sb_resp got k=%0d err=%b dat=%h, exp k=%0d err=%b dat=%h",
                                     k, m_err_o[k], m_dat_o, mon_e.k, mon_e.err, mon_e.dat);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_e(input int k, input bit err, input bit rd, input logic [31:0] d);
        exp_t e;
        e.k = k;
        e.err = err;
        e.rd = rd;
        e.dat = d;
        sbq.push_back(e);
    endtask

    task automatic push_seq(input int k, input logic [31:0] old);
        repeat (3) push_e(k, 1'b0, 1'b0, 32'h0);
        push_e(k, 1'b0, 1'b1, old);
    endtask

    task automatic acc(input int k, input bit we, input logic [31:0] a,
                       input logic [31:0] d, output bit stb_seen);
        int n;
        t_adr[k] = a;
        t_dat[k] = d;
        t_we[k]  = we;
        t_cyc[k] = 1'b1;
        t_stb[k] = 1'b1;
        n = 0;
        stb_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (m_ack_o[k] || m_err_o[k]) begin
                stb_seen = s_stb_o;
                break;
            end
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL acc_timeout k=%0d got=none exp=ack", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        t_cyc[k] = 1'b0;
        t_stb[k] = 1'b0;
        t_we[k]  = 1'b0;
    endtask

    task automatic do_seq(input int k, input logic [31:0] a,
                          input logic [31:0] c, input logic [31:0] v);
        bit sb;
        acc(k, 1'b1, 32'h0, a, sb);
        acc(k, 1'b1, 32'h4, c, sb);
        acc(k, 1'b1, 32'h8, v, sb);
        acc(k, 1'b0, 32'hC, 32'h0, sb);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_%0d", k), 32'(done[k]), 32'd1);
    endtask

    initial begin
        bit sb;
        int n;
        int p0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h5;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[3] = 32'h33;
        for (int i = 0; i < N; i++) begin
            t_adr[i] = '0;
            t_dat[i] = '0;
            t_we[i]  = 1'b0;
            t_cyc[i] = 1'b0;
            t_stb[i] = 1'b0;
        end
        done = '1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        chk("rst_err", 32'(m_err_o), 32'd0);
        chk("rst_rty", 32'(m_rty_o), 32'd0);
        chk("rst_cas_rst", 32'(cas_rst_o), 32'd0);

        // Single requester full CAS
        @(posedge clk) #1;
        push_seq(0, 32'h5);
        do_seq(0, 32'h1000, 32'h5, 32'h7);

        // rr pointer moved to 1: requester 2 beats requester 0
        push_seq(2, 32'h11);
        push_seq(0, 32'h7);
        done[2] = 1'b0;
        fork
            begin do_seq(2, 32'h1004, 32'h11, 32'hAA); done[2] = 1'b1; end
        join_none
        do_seq(0, 32'h1000, 32'h5, 32'h9);
        wait_done(2);

        @(posedge clk) #1 rst_i = 1'b1;
        @(posedge clk) #1 rst_i = 1'b0;

        // Requesters 1 and 2 together
        push_seq(1, 32'h22);
        push_seq(2, 32'h7);
        done[2] = 1'b0;
        fork
            begin do_seq(2, 32'h1000, 32'h7, 32'h8); done[2] = 1'b1; end
        join_none
        do_seq(1, 32'h1008, 32'h22, 32'h23);
        @(negedge clk);
        chk("t2_idle_gap", 32'(s_cyc_o), 32'd0);
        @(negedge clk);
        chk("t2_grant2_cyc", 32'(s_cyc_o), 32'd1);
        chk("t2_grant2_dat", s_dat_o, 32'h1000);
        wait_done(2);

        // Wrong direction in phase 0
        push_e(0, 1'b1, 1'b0, 32'h0);
        acc(0, 1'b0, 32'h0, 32'h0, sb);
        chk("t3_stb_on_err", 32'(sb), 32'd0);
        push_seq(0, 32'h33);
        do_seq(0, 32'h100C, 32'h0, 32'h1);

        // Abandon after two writes: abort pulse, then requester 3
        push_e(0, 1'b0, 1'b0, 32'h0);
        push_e(0, 1'b0, 1'b0, 32'h0);
        acc(0, 1'b1, 32'h0, 32'h1000, sb);
        acc(0, 1'b1, 32'h4, 32'h8, sb);
        p0 = rst_pulses;
        push_seq(3, 32'h8);
        done[3] = 1'b0;
        fork
            begin do_seq(3, 32'h1000, 32'h8, 32'h55); done[3] = 1'b1; end
        join_none
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (cas_rst_o) break;
        end
        chk("t4_abort_delay", 32'(n), 32'(T + 1));
        wait_done(3);
        chk("t4_abort_pulses", 32'(rst_pulses - p0), 32'd1);

        // Granted but silent owner: release without abort
        p0 = rst_pulses;
        @(posedge clk) #1;
        t_cyc[0] = 1'b1;
        t_stb[0] = 1'b1;
        t_we[0]  = 1'b1;
        @(posedge clk) #1;
        t_cyc[0] = 1'b0;
        t_stb[0] = 1'b0;
        t_we[0]  = 1'b0;
        push_seq(1, 32'hAA);
        done[1] = 1'b0;
        fork
            begin do_seq(1, 32'h1004, 32'hAA, 32'hBB); done[1] = 1'b1; end
        join_none
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (s_cyc_o) break;
        end
        chk("t5_release_delay", 32'(n), 32'(T + 2));
        wait_done(1);
        chk("t5_no_abort", 32'(rst_pulses - p0), 32'd0);

        // Reset during a slow phase-3 read
        rd_wait = 50;
        repeat (3) push_e(2, 1'b0, 1'b0, 32'h0);
        done[2] = 1'b0;
        fork
            begin
                bit sb2;
                acc(2, 1'b1, 32'h0, 32'h1008, sb2);
                acc(2, 1'b1, 32'h4, 32'h23, sb2);
                acc(2, 1'b1, 32'h8, 32'h24, sb2);
                acc(2, 1'b0, 32'hC, 32'h0, sb2);
                done[2] = 1'b1;
            end
        join_none
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (s_stb_o && !s_we_o) break;
        end
        chk("t6_read_pending", 32'(s_stb_o && !s_we_o), 32'd1);
        @(posedge clk) #1 rst_i = 1'b1;
        rd_wait = 2;
        push_seq(0, 32'h23);
        push_e(2, 1'b1, 1'b0, 32'h0);
        done[0] = 1'b0;
        fork
            begin do_seq(0, 32'h1008, 32'h23, 32'h30); done[0] = 1'b1; end
        join_none
        @(posedge clk);
        @(negedge clk);
        chk("t6_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("t6_s_stb", 32'(s_stb_o), 32'd0);
        chk("t6_ack", 32'(m_ack_o), 32'd0);
        chk("t6_err", 32'(m_err_o), 32'd0);
        chk("t6_cas_rst", 32'(cas_rst_o), 32'd0);
        @(posedge clk) #1 rst_i = 1'b0;
        wait_done(0);
        wait_done(2);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
